seg7_reader: RTL and testbench

- Inverse of the team's BCD-to-seven-segment driver: samples a live seven-segment bus (a..g plus digit select) and recovers the 4-bit BCD digit being shown.
- Applies a stability filter, so scan glitches and transitions are never reported.
- Each newly stable digit is reported with a one-cycle valid pulse.
- Used on the board-test path to read back what the display logic drives, without a camera or a human in the loop.

---
 rtl/seg7_reader.sv | 188 ++++++++++++++++++
 tb/tb_seg7_reader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seg7_reader.sv
// seg7_reader
// Samples a live seven-segment bus (segments a..g plus active-low digit
// select) and recovers the BCD digit being displayed. A pattern must be
// seen on STABLE_CYCLES consecutive enabled samples before it is accepted,
// so scan glitches and transitions are never reported. Each accepted value
// that differs from the last reported one produces a one-cycle valid pulse.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset
//   a..g   - segment inputs, active-high, asynchronous to clk
//   sel    - digit select, active-low (digit lit when sel=0)
//   data   - last accepted BCD digit (4'hF for an illegal pattern)
//   err    - last accepted pattern was not a legal digit
//   valid  - one-cycle pulse: data/err were just updated
//   locked - high while a stable pattern is locked
module seg7_reader #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  input  logic       sel,
  output logic [3:0] data,
  output logic       err,
  output logic       valid,
  output logic       locked
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILTER = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  // Pattern {a..g} to {err, data}; anything outside the ten digits is an error.
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'b1111110: res = {1'b0, 4'd0};
      7'b0110000: res = {1'b0, 4'd1};
      7'b1101101: res = {1'b0, 4'd2};
      7'b1111001: res = {1'b0, 4'd3};
      7'b0110011: res = {1'b0, 4'd4};
      7'b1011011: res = {1'b0, 4'd5};
      7'b1011111: res = {1'b0, 4'd6};
      7'b1110000: res = {1'b0, 4'd7};
      7'b1111111: res = {1'b0, 4'd8};
      7'b1111011: res = {1'b0, 4'd9};
      default:    res = {1'b1, 4'hF};
    endcase
    return res;
  endfunction

  state_t           state_q, state_d;
  logic [6:0]       pat_q, pat_d;
  logic             en_q, en_d;
  logic [6:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             have_report_q, have_report_d;
  logic [3:0]       data_q, data_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;

  logic             sample_en_s;
  logic             accept_s;
  logic [4:0]       dec_s;

  // A blank pattern is treated as display off even when the digit is selected.
  assign sample_en_s = en_q && (pat_q != 7'b0000000);
  assign dec_s       = decode_seg(cand_q);

  // Next-state, filter counter and report logic.
  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    cnt_d         = cnt_q;
    have_report_d = have_report_q;
    data_d        = data_q;
    err_d         = err_q;
    valid_d       = 1'b0;
    accept_s      = 1'b0;
    pat_d         = {a, b, c, d, e, f, g};
    en_d          = ~sel;

    case (state_q)
      IDLE: begin
        if (sample_en_s) begin
          cand_d  = pat_q;
          cnt_d   = CNT_ONE;
          state_d = FILTER;
        end else begin
          state_d = IDLE;
        end
      end
      FILTER: begin
        if (!sample_en_s) begin
          cnt_d   = CNT_ZERO;
          state_d = IDLE;
        end else if (pat_q != cand_q) begin
          cand_d = pat_q;
          cnt_d  = CNT_ONE;
        end else if (cnt_q < CNT_LAST) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          accept_s = 1'b1;
          state_d  = LOCKED;
        end
      end
      LOCKED: begin
        if (!sample_en_s) begin
          state_d = IDLE;
        end else if (pat_q != cand_q) begin
          cand_d  = pat_q;
          cnt_d   = CNT_ONE;
          state_d = FILTER;
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        cnt_d   = CNT_ZERO;
        state_d = IDLE;
      end
    endcase

    // Re-lighting the same digit during scanning must not re-report it.
    if (accept_s) begin
      if (!have_report_q || (dec_s != {err_q, data_q})) begin
        err_d   = dec_s[4];
        data_d  = dec_s[3:0];
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
      have_report_d = 1'b1;
    end else begin
      have_report_d = have_report_q;
    end

    locked_d = (state_d == LOCKED);
  end

  // State, input sample register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pat_q         <= 7'b0000000;
      en_q          <= 1'b0;
      cand_q        <= 7'b0000000;
      cnt_q         <= CNT_ZERO;
      have_report_q <= 1'b0;
      data_q        <= 4'h0;
      err_q         <= 1'b0;
      valid_q       <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pat_q         <= pat_d;
      en_q          <= en_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      have_report_q <= have_report_d;
      data_q        <= data_d;
      err_q         <= err_d;
      valid_q       <= valid_d;
      locked_q      <= locked_d;
    end
  end

  assign data   = data_q;
  assign err    = err_q;
  assign valid  = valid_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_seg7_reader.sv
module tb_seg7_reader;

  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a, b, c, d, e, f, g;
  logic       sel = 1'b1;
  logic [3:0] data;
  logic       err, valid, locked;

  logic [6:0] cur_pat = 7'b0000000;
  assign {a, b, c, d, e, f, g} = cur_pat;

  seg7_reader #(.STABLE_CYCLES(SC), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .sel(sel), .data(data), .err(err), .valid(valid), .locked(locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    logic [3:0] d;
    logic       e;
  } exp_t;
  exp_t q[$];
  bit exp_locked[int];

  // Reference model state: length of the current run of identical enabled samples.
  int         run_len = 0;
  logic [6:0] run_pat = 7'b0;
  bit         have_rep = 0;
  logic [3:0] held_d = 4'h0;
  logic       held_e = 1'b0;

  logic [6:0] digit_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: the vector applied now is sampled at the next edge and judged one edge later.
  task automatic model_apply(input logic [6:0] pat, input logic s);
    bit   en;
    int   digit;
    logic [3:0] dd;
    logic       ee;
    en = (s == 1'b0) && (pat != 7'b0);
    if (!en) run_len = 0;
    else if (run_len > 0 && pat == run_pat) run_len++;
    else begin
      run_pat = pat;
      run_len = 1;
    end
    if (run_len > SC + 1) run_len = SC + 1;
    if (en && run_len == SC) begin
      digit = -1;
      for (int i = 0; i < 10; i++) if (digit_tab[i] == pat) digit = i;
      dd = (digit < 0) ? 4'hF : 4'(digit);
      ee = (digit < 0);
      if (!have_rep || dd != held_d || ee != held_e)
        q.push_back('{cyc: cyc + 2, d: dd, e: ee});
      held_d = dd;
      held_e = ee;
      have_rep = 1;
    end
    exp_locked[cyc + 2] = en && (run_len >= SC);
  endtask

  task automatic hold(input logic [6:0] pat, input logic s, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cur_pat = pat;
      sel = s;
      model_apply(pat, s);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1 rst = 1'b1;
    while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
    exp_locked.delete(cyc + 1);
    exp_locked.delete(cyc + 2);
    run_len = 0;
    have_rep = 0;
    held_d = 4'h0;
    held_e = 1'b0;
    repeat (n) @(negedge clk);
    #1 rst = 1'b0;
    model_apply(cur_pat, sel);
  endtask

  // Monitor: pops expected reports whenever the DUT presents valid.
  always @(negedge clk) begin
    if (rst) begin
      check("reset_data", int'(data), 0);
      check("reset_err", int'(err), 0);
      check("reset_valid", int'(valid), 0);
      check("reset_locked", int'(locked), 0);
    end else begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        check("report_missing", 0, 1);
        void'(q.pop_front());
      end
      if (valid) begin
        if (q.size() == 0 || q[0].cyc != cyc) begin
          check("unexpected_valid", 1, 0);
        end else begin
          check("report_data", int'(data), int'(q[0].d));
          check("report_err", int'(err), int'(q[0].e));
          void'(q.pop_front());
        end
      end
      if (exp_locked.exists(cyc)) begin
        check("locked", int'(locked), int'(exp_locked[cyc]));
        exp_locked.delete(cyc);
      end
    end
  end

  initial begin
    logic [6:0] p;
    int         k;
    do_reset(2);
    // Lock on 2
    hold(7'b1101101, 1'b0, 10);
    // Deselect, reselect same digit: relock without a report
    hold(7'b1101101, 1'b1, 3);
    hold(7'b1101101, 1'b0, 8);
    // 9 with a one-sample glitch to 8
    hold(7'b1111011, 1'b0, 2);
    hold(7'b1111111, 1'b0, 1);
    hold(7'b1111011, 1'b0, 8);
    // Illegal pattern then 1
    hold(7'b1000001, 1'b0, 8);
    hold(7'b0110000, 1'b0, 8);
    // Blank display
    hold(7'b0000000, 1'b0, 20);
    // Reset mid-filter on 7
    hold(7'b1110000, 1'b0, 3);
    do_reset(2);
    hold(7'b1110000, 1'b0, 8);
    // Randomized segments: digits, illegal codes, blanks, deselects and glitches
    for (int i = 0; i < 80; i++) begin
      k = int'($urandom_range(0, 13));
      if (k < 10) p = digit_tab[k];
      else if (k < 12) p = 7'($urandom_range(1, 127));
      else p = 7'b0000000;
      hold(p, ($urandom_range(0, 7) == 0), int'($urandom_range(1, 8)));
      if ($urandom_range(0, 5) == 0) hold(7'($urandom_range(0, 127)), 1'b0, 1);
      if ($urandom_range(0, 30) == 0) do_reset(int'($urandom_range(1, 3)));
    end
    // Drain
    hold(7'b0000000, 1'b1, 4);
    @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
